mem_stage: RTL and testbench

- Memory-access pipeline stage between EX and WB.
- Registers each valid instruction from EX and performs the load or store on a request/grant/response data-memory port.
- Sign/zero-extends load data, then forwards the instruction to WB.
- Back-pressures EX with a ready signal and exposes the in-flight load's destination register to EX's stall controller for load-use hazard detection.

---
 rtl/riviera_pkg.sv | 23 ++
 rtl/mem_lsu_align.sv | 56 +++++
 rtl/mem_stage.sv | 136 +++++++++++++
 tb/tb_mem_stage.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riviera_pkg.sv
// Shared pipeline types: the EX->MEM->WB instruction record and memory access sizes.
package riviera_pkg;

    localparam int XLEN = 64;
    localparam int ALEN = 5;

    typedef enum logic [1:0] {MEM_B, MEM_H, MEM_W, MEM_D} mem_size_t;

    typedef struct packed {
        logic            is_valid;
        logic            mem_rd_en;
        logic            mem_wr_en;
        mem_size_t       mem_size;
        logic            mem_unsigned;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] store_data;
        logic            rf_wr_en;
        logic [ALEN-1:0] rf_wr_addr;
        logic [XLEN-1:0] rf_wr_data;
        logic            misaligned;
    } interconnection_struct;

endpackage

// File: rtl/mem_lsu_align.sv
// Lane alignment for the data port: byte enables, store-data shift,
// misalignment detection and load-data extraction with sign/zero extension.
module mem_lsu_align
    import riviera_pkg::*;
(
    input  logic [2:0]      addr_lo_i,
    input  mem_size_t       size_i,
    input  logic            unsigned_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [7:0]      be_o,
    output logic [XLEN-1:0] wdata_o,
    output logic            misaligned_o,
    output logic [XLEN-1:0] load_data_o
);

    logic [3:0]      nbytes;
    logic [5:0]      shamt;
    logic [XLEN-1:0] shifted;

    assign shamt   = {addr_lo_i, 3'b000};
    assign wdata_o = store_data_i << shamt;
    assign shifted = rdata_i >> shamt;

    always_comb begin
        nbytes       = 4'd1;
        misaligned_o = 1'b0;
        case (size_i)
            MEM_B: begin nbytes = 4'd1; misaligned_o = 1'b0; end
            MEM_H: begin nbytes = 4'd2; misaligned_o = addr_lo_i[0]; end
            MEM_W: begin nbytes = 4'd4; misaligned_o = |addr_lo_i[1:0]; end
            MEM_D: begin nbytes = 4'd8; misaligned_o = |addr_lo_i; end
            default: begin nbytes = 4'd1; misaligned_o = 1'b0; end
        endcase
    end

    // A lane is enabled when it falls inside [offset, offset+size); lanes past 7 drop off.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_be
            assign be_o[gi] = (4'(gi) >= {1'b0, addr_lo_i}) &&
                              (4'(gi) < ({1'b0, addr_lo_i} + nbytes));
        end
    endgenerate

    always_comb begin
        load_data_o = shifted;
        case (size_i)
            MEM_B: load_data_o = {{56{~unsigned_i & shifted[7]}},  shifted[7:0]};
            MEM_H: load_data_o = {{48{~unsigned_i & shifted[15]}}, shifted[15:0]};
            MEM_W: load_data_o = {{32{~unsigned_i & shifted[31]}}, shifted[31:0]};
            MEM_D: load_data_o = shifted;
            default: load_data_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: one outstanding load/store on a req/gnt/rvalid port,
// single-cycle pass-through for non-memory and misaligned instructions.
module mem_stage
    import riviera_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  interconnection_struct i_ex2mem,
    output logic                 o_mem_ready,
    output logic [ALEN-1:0]      o_mem_rd,
    output logic                 o_dmem_req,
    output logic                 o_dmem_we,
    output logic [XLEN-1:0]      o_dmem_addr,
    output logic [7:0]           o_dmem_be,
    output logic [XLEN-1:0]      o_dmem_wdata,
    input  logic                 i_dmem_gnt,
    input  logic                 i_dmem_rvalid,
    input  logic [XLEN-1:0]      i_dmem_rdata,
    output interconnection_struct o_mem2wb,
    output logic [CNT_W-1:0]     o_stall_cycles
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_state_t;

    mem_state_t            state_q;
    interconnection_struct hold_q;
    interconnection_struct wb_q;
    interconnection_struct load_done;
    logic [CNT_W-1:0]      stall_q, stall_d;

    logic [2:0]      acc_addr_lo;
    mem_size_t       acc_size;
    logic            acc_unsigned;
    logic [XLEN-1:0] acc_store_data;
    logic            misaligned;
    logic [XLEN-1:0] load_data;

    // IDLE only needs the alignment check on the incoming op; busy states need lanes of the held op.
    always_comb begin
        if (state_q == IDLE) begin
            acc_addr_lo    = i_ex2mem.alu_result[2:0];
            acc_size       = i_ex2mem.mem_size;
            acc_unsigned   = i_ex2mem.mem_unsigned;
            acc_store_data = i_ex2mem.store_data;
        end else begin
            acc_addr_lo    = hold_q.alu_result[2:0];
            acc_size       = hold_q.mem_size;
            acc_unsigned   = hold_q.mem_unsigned;
            acc_store_data = hold_q.store_data;
        end
    end

    mem_lsu_align u_align (
        .addr_lo_i    (acc_addr_lo),
        .size_i       (acc_size),
        .unsigned_i   (acc_unsigned),
        .store_data_i (acc_store_data),
        .rdata_i      (i_dmem_rdata),
        .be_o         (o_dmem_be),
        .wdata_o      (o_dmem_wdata),
        .misaligned_o (misaligned),
        .load_data_o  (load_data)
    );

    always_comb begin
        load_done            = hold_q;
        load_done.rf_wr_data = load_data;
    end

    always_comb begin
        stall_d = stall_q;
        if (state_q != IDLE && stall_q != '1) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            wb_q    <= '0;
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
            wb_q    <= '0;
            case (state_q)
                IDLE: begin
                    if (i_ex2mem.is_valid) begin
                        if (!(i_ex2mem.mem_rd_en || i_ex2mem.mem_wr_en)) begin
                            wb_q <= i_ex2mem;
                        end else if (misaligned) begin
                            wb_q            <= i_ex2mem;
                            wb_q.misaligned <= 1'b1;
                            wb_q.rf_wr_en   <= 1'b0;
                        end else begin
                            hold_q  <= i_ex2mem;
                            state_q <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (i_dmem_gnt) begin
                        if (hold_q.mem_wr_en) begin
                            wb_q    <= hold_q;
                            state_q <= IDLE;
                        end else if (i_dmem_rvalid) begin
                            wb_q    <= load_done;
                            state_q <= IDLE;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (i_dmem_rvalid) begin
                        wb_q    <= load_done;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_mem_ready    = (state_q == IDLE);
    assign o_dmem_req     = (state_q == REQ);
    assign o_dmem_we      = hold_q.mem_wr_en;
    assign o_dmem_addr    = {hold_q.alu_result[XLEN-1:3], 3'b000};
    assign o_mem_rd       = (state_q != IDLE && hold_q.mem_rd_en && !hold_q.mem_wr_en && hold_q.rf_wr_en)
                            ? hold_q.rf_wr_addr : '0;
    assign o_mem2wb       = wb_q;
    assign o_stall_cycles = stall_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, directed corner sequences and randomized transactions.
module tb_mem_stage;
    import riviera_pkg::*;

    localparam int CW = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    interconnection_struct ex;
    interconnection_struct wb;
    logic                  ready;
    logic [ALEN-1:0]       mrd;
    logic                  req, we;
    logic [XLEN-1:0]       addr, wdata, rdata;
    logic [7:0]            be;
    logic                  gnt, rvalid;
    logic [CW-1:0]         stall;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_stall = 0;

    always #5 clk = ~clk;

    mem_stage #(.CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_ex2mem       (ex),
        .o_mem_ready    (ready),
        .o_mem_rd       (mrd),
        .o_dmem_req     (req),
        .o_dmem_we      (we),
        .o_dmem_addr    (addr),
        .o_dmem_be      (be),
        .o_dmem_wdata   (wdata),
        .i_dmem_gnt     (gnt),
        .i_dmem_rvalid  (rvalid),
        .i_dmem_rdata   (rdata),
        .o_mem2wb       (wb),
        .o_stall_cycles (stall)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic int nbytes(mem_size_t s);
        return 1 << int'(s);
    endfunction

    function automatic logic [CW-1:0] sat(int n);
        return (n >= (1 << CW) - 1) ? '1 : CW'(n);
    endfunction

    function automatic bit is_misal(interconnection_struct i);
        return (int'(i.alu_result[2:0]) % nbytes(i.mem_size)) != 0;
    endfunction

    function automatic logic [7:0] ref_be(int off, int nb);
        logic [7:0] m = '0;
        for (int b = 0; b < nb; b++) if (off + b < 8) m[off + b] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] ref_wdata(logic [63:0] sd, int off);
        logic [63:0] w = '0;
        for (int b = 0; b + off < 8; b++) w[8*(off+b) +: 8] = sd[8*b +: 8];
        return w;
    endfunction

    function automatic logic [63:0] ref_load(logic [63:0] rd, int off, int nb, logic uns);
        logic [63:0] v = '0;
        for (int b = 0; b < nb; b++) v[8*b +: 8] = rd[8*(off+b) +: 8];
        if (!uns && nb < 8 && v[8*nb-1]) for (int b = nb; b < 8; b++) v[8*b +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic interconnection_struct ref_wb(interconnection_struct i, logic [63:0] rd);
        interconnection_struct o = i;
        if (i.mem_rd_en || i.mem_wr_en) begin
            if (is_misal(i)) begin
                o.misaligned = 1'b1;
                o.rf_wr_en   = 1'b0;
            end else if (i.mem_rd_en && !i.mem_wr_en) begin
                o.rf_wr_data = ref_load(rd, int'(i.alu_result[2:0]), nbytes(i.mem_size), i.mem_unsigned);
            end
        end
        return o;
    endfunction

    function automatic interconnection_struct mk(logic rd_en, logic wr_en, mem_size_t sz, logic uns,
                                                 logic [63:0] a, logic [63:0] sd, logic rfwe,
                                                 logic [4:0] rfa, logic [63:0] rfd, logic mis);
        interconnection_struct r;
        r.is_valid     = 1'b1;
        r.mem_rd_en    = rd_en;
        r.mem_wr_en    = wr_en;
        r.mem_size     = sz;
        r.mem_unsigned = uns;
        r.alu_result   = a;
        r.store_data   = sd;
        r.rf_wr_en     = rfwe;
        r.rf_wr_addr   = rfa;
        r.rf_wr_data   = rfd;
        r.misaligned   = mis;
        return r;
    endfunction

    function automatic interconnection_struct rand_instr();
        interconnection_struct r = '0;
        int kind = int'($urandom_range(0, 2));
        r.is_valid     = 1'b1;
        r.mem_size     = mem_size_t'($urandom_range(0, 3));
        r.mem_unsigned = 1'($urandom_range(0, 1));
        r.alu_result   = rand64();
        if ($urandom_range(0, 3) != 0)
            r.alu_result[2:0] = r.alu_result[2:0] & ~3'(nbytes(r.mem_size) - 1);
        r.store_data   = rand64();
        r.rf_wr_addr   = 5'($urandom());
        r.rf_wr_data   = rand64();
        case (kind)
            0: r.rf_wr_en = 1'b1;
            1: begin r.mem_rd_en = 1'b1; r.rf_wr_en = 1'($urandom_range(0, 3) != 0); end
            default: r.mem_wr_en = 1'b1;
        endcase
        return r;
    endfunction

    // One instruction end to end; gw = cycles gnt is held low, rw = cycles after gnt before rvalid.
    task automatic run_txn(input interconnection_struct ins, input int gw, input int rw,
                           input logic [63:0] rd, output interconnection_struct got);
        bit is_mem = ins.mem_rd_en | ins.mem_wr_en;
        bit is_ld  = ins.mem_rd_en & !ins.mem_wr_en;
        int off    = int'(ins.alu_result[2:0]);
        int nb     = nbytes(ins.mem_size);
        interconnection_struct exp = ref_wb(ins, rd);
        logic [ALEN-1:0] exp_rd = (is_ld && ins.rf_wr_en) ? ins.rf_wr_addr : '0;
        check("ready_before", 256'(ready), 256'(1'b1));
        ex = ins;
        tick;
        ex = '0;
        if (!is_mem || is_misal(ins)) begin
            check("wb_single", 256'(wb), 256'(exp));
            check("no_req", 256'(req), 256'(1'b0));
            check("ready_after", 256'(ready), 256'(1'b1));
        end else begin
            check("bubble", 256'(wb.is_valid), 256'(1'b0));
            for (int k = 0; k <= gw; k++) begin
                check("req", 256'(req), 256'(1'b1));
                check("addr", 256'(addr), 256'(ins.alu_result & ~64'h7));
                check("we", 256'(we), 256'(ins.mem_wr_en));
                check("be", 256'(be), 256'(ref_be(off, nb)));
                check("wdata", 256'(wdata), 256'(ref_wdata(ins.store_data, off)));
                check("mem_rd", 256'(mrd), 256'(exp_rd));
                check("ready_busy", 256'(ready), 256'(1'b0));
                gnt = (k == gw);
                if (k < gw) begin
                    rvalid = 1'($urandom_range(0, 1));
                    rdata  = rand64();
                end else if (is_ld && rw == 0) begin
                    rvalid = 1'b1;
                    rdata  = rd;
                end
                tick;
                gnt = 1'b0;
                rvalid = 1'b0;
                exp_stall++;
                if (!(k == gw && (!is_ld || rw == 0)))
                    check("wb_idle_req", 256'(wb.is_valid), 256'(1'b0));
            end
            if (is_ld) begin
                for (int j = 1; j <= rw; j++) begin
                    check("wait_noreq", 256'(req), 256'(1'b0));
                    check("mem_rd_wait", 256'(mrd), 256'(exp_rd));
                    rvalid = (j == rw);
                    rdata  = (j == rw) ? rd : rand64();
                    tick;
                    rvalid = 1'b0;
                    exp_stall++;
                    if (j < rw) check("wb_idle_wait", 256'(wb.is_valid), 256'(1'b0));
                end
            end
            check("wb_result", 256'(wb), 256'(exp));
            check("ready_done", 256'(ready), 256'(1'b1));
        end
        got = wb;
        check("stall", 256'(stall), 256'(sat(exp_stall)));
        tick;
        check("no_dup", 256'(wb.is_valid), 256'(1'b0));
    endtask

    typedef struct {
        interconnection_struct in;
        interconnection_struct exp;
    } vec_t;

    vec_t tbl[6];
    interconnection_struct got;

    initial begin
        tbl[0].in  = mk(0, 0, MEM_B, 0, 64'h40,   64'h0,    1, 5'd5, 64'h1234, 0);
        tbl[0].exp = mk(0, 0, MEM_B, 0, 64'h40,   64'h0,    1, 5'd5, 64'h1234, 0);
        tbl[1].in  = mk(1, 0, MEM_D, 0, 64'h0C,   64'h0,    1, 5'd7, 64'h55,   0);
        tbl[1].exp = mk(1, 0, MEM_D, 0, 64'h0C,   64'h0,    0, 5'd7, 64'h55,   1);
        tbl[2].in  = mk(1, 0, MEM_H, 1, 64'h1001, 64'h0,    1, 5'd3, 64'h0,    0);
        tbl[2].exp = mk(1, 0, MEM_H, 1, 64'h1001, 64'h0,    0, 5'd3, 64'h0,    1);
        tbl[3].in  = mk(0, 1, MEM_W, 0, 64'h2002, 64'hDEAD, 0, 5'd0, 64'h0,    0);
        tbl[3].exp = mk(0, 1, MEM_W, 0, 64'h2002, 64'hDEAD, 0, 5'd0, 64'h0,    1);
        tbl[4].in  = mk(0, 1, MEM_D, 0, 64'h2004, 64'h77,   0, 5'd0, 64'h0,    0);
        tbl[4].exp = mk(0, 1, MEM_D, 0, 64'h2004, 64'h77,   0, 5'd0, 64'h0,    1);
        tbl[5].in  = mk(0, 0, MEM_W, 1, 64'h8,    64'h1,    0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        tbl[5].exp = mk(0, 0, MEM_W, 1, 64'h8,    64'h1,    0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 0);

        rst_n = 1'b0; ex = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        tick; tick;
        check("rst_ready", 256'(ready), 256'(1'b1));
        check("rst_mem_rd", 256'(mrd), 256'(5'd0));
        check("rst_req", 256'(req), 256'(1'b0));
        check("rst_wb", 256'(wb), 256'(0));
        check("rst_stall", 256'(stall), 256'(0));
        rst_n = 1'b1;
        tick;

        for (int i = 0; i < 6; i++) begin
            check("vec_ready", 256'(ready), 256'(1'b1));
            ex = tbl[i].in;
            tick;
            ex = '0;
            check($sformatf("vec%0d_wb", i), 256'(wb), 256'(tbl[i].exp));
            check($sformatf("vec%0d_req", i), 256'(req), 256'(1'b0));
        end

        ex = mk(1, 0, MEM_D, 0, 64'h100, 64'h0, 1, 5'd4, 64'h0, 0);
        ex.is_valid = 1'b0;
        tick;
        ex = '0;
        check("invalid_noreq", 256'(req), 256'(1'b0));
        check("invalid_nowb", 256'(wb.is_valid), 256'(1'b0));

        // LB with sign bit set in the selected lane
        run_txn(mk(1, 0, MEM_B, 0, 64'h1003, 64'h0, 1, 5'd9, 64'h0, 0), 0, 2,
                64'h0000_0000_8000_0000, got);
        check("lb_data", 256'(got.rf_wr_data), 256'(64'hFFFF_FFFF_FFFF_FF80));
        check("lb_stall3", 256'(stall), 256'(4'd3));

        run_txn(mk(0, 1, MEM_H, 0, 64'h2006, 64'hABCD, 0, 5'd0, 64'h0, 0), 2, 0, 64'h0, got);
        check("sh_valid", 256'(got.is_valid), 256'(1'b1));

        run_txn(mk(1, 0, MEM_W, 1, 64'h10, 64'h0, 1, 5'd12, 64'h0, 0), 0, 0,
                64'h0000_0000_FFFF_FFFF, got);
        check("lwu_data", 256'(got.rf_wr_data), 256'(64'h0000_0000_FFFF_FFFF));

        // Reset while a load waits for its response
        ex = mk(1, 0, MEM_D, 0, 64'h3000, 64'h0, 1, 5'd6, 64'h0, 0);
        tick;
        ex = '0;
        gnt = 1'b1;
        tick;
        gnt = 1'b0;
        check("wait_mem_rd", 256'(mrd), 256'(5'd6));
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", 256'(req), 256'(1'b0));
        check("mid_rst_ready", 256'(ready), 256'(1'b1));
        check("mid_rst_wb", 256'(wb), 256'(0));
        check("mid_rst_stall", 256'(stall), 256'(0));
        check("mid_rst_mem_rd", 256'(mrd), 256'(5'd0));
        tick;
        rst_n = 1'b1;
        exp_stall = 0;
        rvalid = 1'b1;
        rdata = 64'h1122_3344_5566_7788;
        tick;
        rvalid = 1'b0;
        check("post_rst_wb", 256'(wb.is_valid), 256'(1'b0));
        check("post_rst_stall", 256'(stall), 256'(0));
        check("post_rst_ready", 256'(ready), 256'(1'b1));

        for (int i = 0; i < 60; i++) begin
            interconnection_struct ri = rand_instr();
            run_txn(ri, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rand64(), got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
